// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder: S = a + b + Cin, CHUNK bits per clock from the LSB, with a
// registered carry between chunks, optional signed saturation and valid/ready on both sides.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             posOverflow,
    output logic             negOverflow,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] raw_q, raw_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             pos_q, pos_d;
    logic             neg_q, neg_d;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] raw_full;
    logic             pos_raw, neg_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            raw_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            pos_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sat_q   <= sat_d;
            a_q     <= a_d;
            b_q     <= b_d;
            raw_q   <= raw_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        a_d     = a_q;
        b_d     = b_q;
        raw_d   = raw_q;
        s_d     = s_q;
        cout_d  = cout_q;
        pos_d   = pos_q;
        neg_d   = neg_q;

        a_chunk  = a_q[cnt_q*CHUNK +: CHUNK];
        b_chunk  = b_q[cnt_q*CHUNK +: CHUNK];
        csum     = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        // Full raw sum as it will stand after this chunk; only meaningful on the last chunk.
        raw_full = raw_q;
        raw_full[cnt_q*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        pos_raw  = ~a_q[WIDTH-1] & ~b_q[WIDTH-1] &  raw_full[WIDTH-1];
        neg_raw  =  a_q[WIDTH-1] &  b_q[WIDTH-1] & ~raw_full[WIDTH-1];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    sat_d   = sat;
                    carry_d = Cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                raw_d   = raw_full;
                carry_d = csum[CHUNK];
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    state_d = DONE;
                    cout_d  = csum[CHUNK];
                    pos_d   = pos_raw;
                    neg_d   = neg_raw;
                    if (sat_q && pos_raw)
                        s_d = {1'b0, {(WIDTH-1){1'b1}}};
                    else if (sat_q && neg_raw)
                        s_d = {1'b1, {(WIDTH-1){1'b0}}};
                    else
                        s_d = raw_full;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign S           = s_q;
    assign Cout        = cout_q;
    assign posOverflow = pos_q;
    assign negOverflow = neg_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: a WIDTH=32/CHUNK=8 and a WIDTH=32/CHUNK=32 instance checked
// against an arithmetic reference model with directed and random operands.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a, b;
    logic        cin, sat, out_ready;
    logic        iv8, iv32;

    logic        ir8, ov8, co8, po8, no8;
    logic [31:0] s8;
    logic [1:0]  st8;
    logic        ir32, ov32, co32, po32, no32;
    logic [31:0] s32;
    logic [1:0]  st32;

    logic        cur_sel;
    logic        cur_ir, cur_ov, cur_co, cur_po, cur_no;
    logic [31:0] cur_s;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b),
        .Cin(cin), .sat(sat), .out_valid(ov8), .out_ready(out_ready), .S(s8), .Cout(co8),
        .posOverflow(po8), .negOverflow(no8), .state_dbg(st8)
    );

    seq_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b),
        .Cin(cin), .sat(sat), .out_valid(ov32), .out_ready(out_ready), .S(s32), .Cout(co32),
        .posOverflow(po32), .negOverflow(no32), .state_dbg(st32)
    );

    always_comb begin
        cur_ir = cur_sel ? ir32 : ir8;
        cur_ov = cur_sel ? ov32 : ov8;
        cur_s  = cur_sel ? s32  : s8;
        cur_co = cur_sel ? co32 : co8;
        cur_po = cur_sel ? po32 : po8;
        cur_no = cur_sel ? no32 : no8;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: widen to 64 bits and compare the true signed sum against the 32-bit range.
    task automatic model(input logic [31:0] aa, input logic [31:0] bb, input logic c,
                         input logic s, output logic [31:0] es, output logic ec,
                         output logic ep, output logic en);
        logic [63:0] u;
        longint      sv;
        u  = {32'h0, aa} + {32'h0, bb} + {63'h0, c};
        sv = longint'($signed(aa)) + longint'($signed(bb)) + (c ? 64'sd1 : 64'sd0);
        ec = u[32];
        ep = (sv > 64'sd2147483647);
        en = (sv < -64'sd2147483648);
        if (s && ep)      es = 32'h7FFF_FFFF;
        else if (s && en) es = 32'h8000_0000;
        else              es = u[31:0];
    endtask

    task automatic do_op(input logic sel, input logic [31:0] aa, input logic [31:0] bb,
                         input logic c, input logic s, input int hold);
        logic [31:0] es;
        logic        ec, ep, en;
        int          cyc;
        model(aa, bb, c, s, es, ec, ep, en);
        cur_sel = sel;
        @(negedge clk);
        check("in_ready_idle", {31'b0, cur_ir}, 32'd1);
        a = aa; b = bb; cin = c; sat = s;
        if (sel) iv32 = 1'b1; else iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0; iv32 = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sat = ~s;
        cyc = 0;
        while (!cur_ov && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), sel ? 32'd1 : 32'd4);
        check("S", cur_s, es);
        check("Cout", {31'b0, cur_co}, {31'b0, ec});
        check("posOverflow", {31'b0, cur_po}, {31'b0, ep});
        check("negOverflow", {31'b0, cur_no}, {31'b0, en});
        check("in_ready_busy", {31'b0, cur_ir}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
            if (sel) iv32 = 1'b1; else iv8 = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", {31'b0, cur_ov}, 32'd1);
            check("hold_S", cur_s, es);
            check("hold_in_ready", {31'b0, cur_ir}, 32'd0);
        end
        @(negedge clk);
        iv8 = 1'b0; iv32 = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", {31'b0, cur_ov}, 32'd0);
        check("release_in_ready", {31'b0, cur_ir}, 32'd1);
        check("release_S_held", cur_s, es);
        check("release_Cout_held", {31'b0, cur_co}, {31'b0, ec});
    endtask

    initial begin
        a = '0; b = '0; cin = 1'b0; sat = 1'b0; out_ready = 1'b0;
        iv8 = 1'b0; iv32 = 1'b0; cur_sel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ov8", {31'b0, ov8}, 32'd0);
        check("rst_ir8", {31'b0, ir8}, 32'd1);
        check("rst_s8", s8, 32'd0);
        check("rst_flags8", {29'b0, co8, po8, no8}, 32'd0);
        check("rst_ov32", {31'b0, ov32}, 32'd0);
        check("rst_ir32", {31'b0, ir32}, 32'd1);
        rst_n = 1'b1;

        do_op(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0);
        do_op(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        do_op(1'b0, 32'h0000_00FF, 32'h1, 1'b0, 1'b0, 0);
        do_op(1'b0, -32'sd10, -32'sd8, 1'b0, 1'b0, 0);
        do_op(1'b0, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b1, 1);
        do_op(1'b0, 32'd100, 32'd50, 1'b1, 1'b0, 5);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);

        // Abandon an operation two cycles into RUN.
        cur_sel = 1'b0;
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h0FED_CBA9; cin = 1'b1; sat = 1'b0; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_ov", {31'b0, ov8}, 32'd0);
        check("midrun_S", s8, 32'd0);
        check("midrun_flags", {29'b0, co8, po8, no8}, 32'd0);
        check("midrun_ir", {31'b0, ir8}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, -32'sd30, 32'd40, 1'b1, 1'b0, 0);

        do_op(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 0);
        do_op(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, 2);
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'h7FFF_FFFF;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: begin ra = {1'b0, ra[30:0]}; rb = {1'b0, rb[30:0]}; end
                default: ;
            endcase
            do_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
